bmaxpool_seq: RTL and testbench

Streaming sequencer for the binary 2x2 max-pool stage of the BNN. It accepts one I_SIZE-bit feature-map row per handshake, buffers the even row, and ORs it with the odd row in 2x2 windows. It emits one O_SIZE-bit pooled row per row pair and signals end of frame. It sits between the upstream binary conv layer's row stream and the next layer's row consumer, and replaces whole-map combinational pooling with a row-serial, back-pressured datapath.

---
 rtl/bmaxpool_seq.sv | 139 +++++++++++++
 tb/tb_bmaxpool_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmaxpool_seq.sv
// bmaxpool_seq: row-serial binary 2x2 max-pool sequencer.
// Takes one I_SIZE-bit row per in handshake, buffers the even row, ORs it with
// the following odd row in 2x2 windows and emits one O_SIZE-bit pooled row per
// row pair. For odd I_SIZE the trailing column and trailing row are discarded.
// Optional feature macro: BMAXPOOL_SEQ_ABORT_EN adds the abort input.
module bmaxpool_seq #(
  parameter  int unsigned I_SIZE = 26,
  localparam int unsigned O_SIZE = I_SIZE / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_SIZE-1:0] in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [O_SIZE-1:0] out_row,
  output logic              out_last,
  output logic              done
`ifdef BMAXPOOL_SEQ_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned CntW    = $clog2(O_SIZE + 1);
  localparam bit          OddSize = (I_SIZE % 2) == 1;

  typedef enum logic [2:0] {StIdle, StEven, StOdd, StOut, StDrop} state_e;

  state_e              state_q, state_d;
  logic [I_SIZE-1:0]   row_buf_q;
  logic [CntW-1:0]     row_cnt_q;
  logic [O_SIZE-1:0]   out_row_q;
  logic                out_last_q;
  logic                done_q;
  logic [O_SIZE-1:0]   pooled;
  logic                in_hs;
  logic                out_hs;
  logic                abort_hit;

`ifdef BMAXPOOL_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q != StIdle);
`else
  assign abort_hit = 1'b0;
`endif

  // With odd I_SIZE the top column never reaches a window.
  logic unused_top_col;
  assign unused_top_col = in_row[I_SIZE-1] ^ row_buf_q[I_SIZE-1];

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // 2x2 OR window over the buffered even row and the incoming odd row.
  always_comb begin
    pooled = '0;
    for (int j = 0; j < int'(O_SIZE); j++) begin
      pooled[j] = row_buf_q[2*j] | row_buf_q[2*j+1] | in_row[2*j] | in_row[2*j+1];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides any handshake in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StEven;
      StEven: if (in_valid) state_d = StOdd;
      StOdd:  if (in_valid) state_d = StOut;
      StOut: begin
        if (out_ready) begin
          if (!out_last_q) state_d = StEven;
          else if (OddSize) state_d = StDrop;
          else state_d = StIdle;
        end
      end
      StDrop: if (in_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  // Handshake signals decoded from the registered state only.
  always_comb begin
    busy      = state_q != StIdle;
    in_ready  = (state_q == StEven) || (state_q == StOdd) || (state_q == StDrop);
    out_valid = state_q == StOut;
  end

  // Datapath: row buffer, row counter, pooled output and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_buf_q  <= '0;
      row_cnt_q  <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_hit) begin
        row_cnt_q  <= '0;
        out_last_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: if (start) row_cnt_q <= '0;
          StEven: if (in_hs) row_buf_q <= in_row;
          StOdd: begin
            if (in_hs) begin
              out_row_q  <= pooled;
              out_last_q <= row_cnt_q == CntW'(O_SIZE - 1);
            end
          end
          StOut: begin
            if (out_hs) begin
              out_last_q <= 1'b0;
              if (!out_last_q) row_cnt_q <= row_cnt_q + CntW'(1);
              else if (!OddSize) done_q <= 1'b1;
            end
          end
          StDrop: if (in_hs) done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign out_row  = out_row_q;
  assign out_last = out_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bmaxpool_seq.sv
// Directed bench for bmaxpool_seq: three instances (I_SIZE 4, 26, 5).
module tb_bmaxpool_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic rst;

  // Instance A: I_SIZE=4
  logic       a_start, a_busy, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_out_last, a_done;
  logic [3:0] a_in_row;
  logic [1:0] a_out_row;
`ifdef BMAXPOOL_SEQ_ABORT_EN
  logic       a_abort;
`endif

  // Instance B: I_SIZE=26
  logic        b_start, b_busy, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_out_last, b_done;
  logic [25:0] b_in_row;
  logic [12:0] b_out_row;

  // Instance C: I_SIZE=5
  logic       c_start, c_busy, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic       c_out_last, c_done;
  logic [4:0] c_in_row;
  logic [1:0] c_out_row;

  bmaxpool_seq #(.I_SIZE(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_row(a_out_row),
    .out_last(a_out_last), .done(a_done)
`ifdef BMAXPOOL_SEQ_ABORT_EN
    , .abort(a_abort)
`endif
  );

  bmaxpool_seq #(.I_SIZE(26)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
    .out_last(b_out_last), .done(b_done)
`ifdef BMAXPOOL_SEQ_ABORT_EN
    , .abort(1'b0)
`endif
  );

  bmaxpool_seq #(.I_SIZE(5)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_row(c_in_row),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_row(c_out_row),
    .out_last(c_out_last), .done(c_done)
`ifdef BMAXPOOL_SEQ_ABORT_EN
    , .abort(1'b0)
`endif
  );

  typedef struct packed {
    logic [3:0] ev;
    logic [3:0] od;
    logic [1:0] exp_row;
    logic       exp_last;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Callers sit on a negedge; returns on the negedge after the row is taken.
  task automatic a_push(input logic [3:0] r);
    int n = 0;
    while (!a_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_push_ready_timeout", 32'(n < 20), 32'd1);
    a_in_valid = 1'b1;
    a_in_row   = r;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_row   = '0;
  endtask

  task automatic c_push(input logic [4:0] r);
    int n = 0;
    while (!c_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_push_ready_timeout", 32'(n < 20), 32'd1);
    c_in_valid = 1'b1;
    c_in_row   = r;
    @(negedge clk);
    c_in_valid = 1'b0;
    c_in_row   = '0;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_take_out();
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int got;

    rst = 1'b1;
    a_start = 0; a_in_valid = 0; a_in_row = '0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_row = '0; b_out_ready = 0;
    c_start = 0; c_in_valid = 0; c_in_row = '0; c_out_ready = 0;
`ifdef BMAXPOOL_SEQ_ABORT_EN
    a_abort = 1'b0;
`endif

    // Three frames of two row pairs each; odd entries close a frame.
    vecs[0] = '{ev: 4'b0001, od: 4'b0000, exp_row: 2'b01, exp_last: 1'b0};
    vecs[1] = '{ev: 4'b0000, od: 4'b1000, exp_row: 2'b10, exp_last: 1'b1};
    vecs[2] = '{ev: 4'b0100, od: 4'b0010, exp_row: 2'b11, exp_last: 1'b0};
    vecs[3] = '{ev: 4'b0000, od: 4'b0000, exp_row: 2'b00, exp_last: 1'b1};
    vecs[4] = '{ev: 4'b1111, od: 4'b0000, exp_row: 2'b11, exp_last: 1'b0};
    vecs[5] = '{ev: 4'b0000, od: 4'b0001, exp_row: 2'b01, exp_last: 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_row", 32'(a_out_row), 32'd0);
    chk("rst_out_last", 32'(a_out_last), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);

    // Table-driven frames on instance A.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        a_pulse_start();
        chk("a_busy_after_start", 32'(a_busy), 32'd1);
      end
      a_push(vecs[i].ev);
      a_push(vecs[i].od);
      chk("a_out_valid", 32'(a_out_valid), 32'd1);
      chk("a_out_row", 32'(a_out_row), 32'(vecs[i].exp_row));
      chk("a_out_last", 32'(a_out_last), 32'(vecs[i].exp_last));
      chk("a_in_ready_out", 32'(a_in_ready), 32'd0);
      a_take_out();
      chk("a_out_valid_clr", 32'(a_out_valid), 32'd0);
      chk("a_done", 32'(a_done), 32'(vecs[i].exp_last));
      chk("a_busy_end", 32'(a_busy), 32'(!vecs[i].exp_last));
    end
    @(negedge clk);
    chk("a_done_one_cycle", 32'(a_done), 32'd0);

    // Back-pressure: hold OUT for 10 cycles with a tempting row on the input.
    a_pulse_start();
    a_push(4'b0010);
    a_push(4'b0000);
    a_in_valid = 1'b1;
    a_in_row   = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
      chk("bp_out_row", 32'(a_out_row), 32'd1);
      chk("bp_out_last", 32'(a_out_last), 32'd0);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_in_row   = '0;
    a_take_out();
    chk("bp_in_ready_even", 32'(a_in_ready), 32'd1);
    a_push(4'b0000);
    a_push(4'b0000);
    chk("bp_out_row2", 32'(a_out_row), 32'd0);
    chk("bp_out_last2", 32'(a_out_last), 32'd1);
    a_take_out();
    chk("bp_done", 32'(a_done), 32'd1);

    // rst in ODD, then a fresh frame.
    a_pulse_start();
    a_push(4'b1111);
    chk("rst_mid_in_ready", 32'(a_in_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(a_busy), 32'd0);
    chk("rst_mid_done", 32'(a_done), 32'd0);
    @(negedge clk);
    chk("rst_mid_done2", 32'(a_done), 32'd0);
    a_pulse_start();
    a_push(4'b0000);
    a_push(4'b0000);
    chk("rst_new_row", 32'(a_out_row), 32'd0);
    chk("rst_new_last", 32'(a_out_last), 32'd0);
    a_take_out();
    a_push(4'b0000);
    a_push(4'b0100);
    chk("rst_new_row2", 32'(a_out_row), 32'd2);
    chk("rst_new_last2", 32'(a_out_last), 32'd1);
    a_take_out();
    chk("rst_new_done", 32'(a_done), 32'd1);

`ifdef BMAXPOOL_SEQ_ABORT_EN
    // Abort during OUT beats the simultaneous output handshake.
    a_pulse_start();
    a_push(4'b0001);
    a_push(4'b0000);
    a_abort     = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_abort     = 1'b0;
    a_out_ready = 1'b0;
    chk("ab_out_valid", 32'(a_out_valid), 32'd0);
    chk("ab_busy", 32'(a_busy), 32'd0);
    chk("ab_done", 32'(a_done), 32'd0);
    @(negedge clk);
    chk("ab_done2", 32'(a_done), 32'd0);
    // abort with start in IDLE: start wins; then abort from EVEN.
    a_abort = 1'b1;
    a_start = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    a_start = 1'b0;
    chk("ab_start_wins", 32'(a_busy), 32'd1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("ab_even_idle", 32'(a_busy), 32'd0);
    chk("ab_even_done", 32'(a_done), 32'd0);
`endif

    // Instance C (I_SIZE=5): trailing column ignored, trailing row dropped.
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_push(5'b10001);
    c_push(5'b00000);
    chk("c_row0", 32'(c_out_row), 32'd1);
    chk("c_last0", 32'(c_out_last), 32'd0);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    c_push(5'b00000);
    c_push(5'b00000);
    chk("c_row1", 32'(c_out_row), 32'd0);
    chk("c_last1", 32'(c_out_last), 32'd1);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    chk("c_drop_busy", 32'(c_busy), 32'd1);
    chk("c_drop_in_ready", 32'(c_in_ready), 32'd1);
    chk("c_drop_no_done", 32'(c_done), 32'd0);
    chk("c_drop_out_valid", 32'(c_out_valid), 32'd0);
    @(negedge clk);
    chk("c_drop_no_done2", 32'(c_done), 32'd0);
    c_push(5'b11111);
    chk("c_done", 32'(c_done), 32'd1);
    chk("c_busy_end", 32'(c_busy), 32'd0);
    @(negedge clk);
    chk("c_done_pulse", 32'(c_done), 32'd0);

    // start coincident with rst is ignored.
    rst     = 1'b1;
    c_start = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    c_start = 1'b0;
    chk("c_start_rst", 32'(c_busy), 32'd0);
    @(negedge clk);
    chk("c_start_rst2", 32'(c_busy), 32'd0);

    // Instance B (I_SIZE=26): full-rate frame, 39 cycles EVEN->done.
    b_in_valid  = 1'b1;
    b_in_row    = 26'h2AAAAAA;
    b_out_ready = 1'b1;
    b_start     = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    got = 0;
    while (!b_done && cyc < 100) begin
      if (b_out_valid) begin
        got++;
        chk("b_out_row", 32'(b_out_row), 32'h1FFF);
        chk("b_out_last", 32'(b_out_last), 32'(got == 13));
      end
      @(negedge clk);
      cyc++;
    end
    b_in_valid = 1'b0;
    chk("b_cycles", 32'(cyc), 32'd39);
    chk("b_rows", 32'(got), 32'd13);
    chk("b_busy_end", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
